// File: rtl/vproc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mem_pkg
// Description : Shared types and constants for the vproc_mem memory model.
//               Contents:
//                 state_t           - request FSM state encoding
//                 c_seg_msb         - top bit of the segment-select field
//                 c_seg_lsb         - bottom bit of the segment-select field
//                 c_max_wait_states - largest supported wait-state count
// Revision    : 1.0 - initial release
// ============================================================================
package vproc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int c_seg_msb         = 31;
    localparam int c_seg_lsb         = 28;
    localparam int c_max_wait_states = 15;

endpackage : vproc_mem_pkg
`default_nettype wire

// File: rtl/vproc_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mem_array
// Description : Single-port DEPTH x DATA_WIDTH storage. Synchronous write
//               with per-byte lane mask and a registered synchronous read.
//               Array contents are never cleared; only the read register
//               is reset.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (read register only)
//               i_we    - write strobe
//               i_re    - read strobe (loads o_rdata)
//               i_idx   - word index
//               i_wdata - write data
//               i_be    - byte lane enables for writes
//               o_rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [DEPTH_LOG2-1:0]   i_idx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_depth = 1 << DEPTH_LOG2;
    localparam int c_lanes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < c_lanes; l++) begin
                if (i_be[l]) begin
                    r_mem[i_idx][l*8 +: 8] <= i_wdata[l*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule : vproc_mem_array
`default_nettype wire

// File: rtl/vproc_mem.sv
`default_nettype none
// ============================================================================
// Module      : vproc_mem
// Description : Parametrised single-port memory model for a VProc node.
//               Decodes Addr[31:28] == BASE_SEG, accepts one request at a
//               time, inserts WAIT_STATES cycles and returns a registered
//               one-cycle WRAck or RDAck. Read data is registered and held
//               until the next read completes.
//               Build option VPROC_MEM_BYTE_EN adds the BE lane-enable port;
//               without it every write updates the full word.
// Ports       : Clk   - clock, rising edge
//               Reset - synchronous active-high reset
//               Addr  - word address (segment in [31:28], index in low bits)
//               WE    - write request, held until WRAck
//               RD    - read request, held until RDAck
//               DI    - write data
//               BE    - byte lane enables (VPROC_MEM_BYTE_EN only)
//               DO    - registered read data
//               WRAck - one-cycle write acknowledge
//               RDAck - one-cycle read acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_mem
    import vproc_mem_pkg::*;
#(
    parameter int         DATA_WIDTH  = 32,
    parameter int         DEPTH_LOG2  = 10,
    parameter logic [3:0] BASE_SEG    = 4'hA,
    parameter int         WAIT_STATES = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [31:0]             Addr,
    input  logic                    WE,
    input  logic                    RD,
    input  logic [DATA_WIDTH-1:0]   DI,
`ifdef VPROC_MEM_BYTE_EN
    input  logic [DATA_WIDTH/8-1:0] BE,
`endif
    output logic [DATA_WIDTH-1:0]   DO,
    output logic                    WRAck,
    output logic                    RDAck
);

    localparam int         c_lanes     = DATA_WIDTH / 8;
    // Counter preload; unused when there are no wait states.
    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [c_lanes-1:0]      r_be;
    logic                    r_write;
    logic                    r_wrack;
    logic                    r_rdack;

    logic                    w_cs;
    logic                    w_req;
    logic                    w_accept;
    logic                    w_enter_ack;
    logic [c_lanes-1:0]      w_be_in;
    logic [DEPTH_LOG2-1:0]   w_op_idx;
    logic [DATA_WIDTH-1:0]   w_op_data;
    logic [c_lanes-1:0]      w_op_be;
    logic                    w_op_write;
    logic                    w_unused_addr;

`ifdef VPROC_MEM_BYTE_EN
    assign w_be_in = BE;
`else
    assign w_be_in = '1;
`endif

    // Address bits between the index and the segment field are ignored.
    assign w_unused_addr = ^Addr;

    assign w_cs     = (Addr[c_seg_msb:c_seg_lsb] == BASE_SEG);
    assign w_req    = w_cs && (WE || RD);
    assign w_accept = (r_state == ST_IDLE) && w_req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // With zero wait states the array is accessed on the acceptance edge
    // itself, before the capture registers hold the request, so the live
    // inputs are forwarded in that case. Write has priority over read.
    assign w_op_idx    = w_accept ? Addr[DEPTH_LOG2-1:0] : r_idx;
    assign w_op_data   = w_accept ? DI                   : r_data;
    assign w_op_be     = w_accept ? w_be_in              : r_be;
    assign w_op_write  = w_accept ? WE                   : r_write;

    // Gated by Reset so that a reset in WAIT drops a pending write.
    assign w_enter_ack = (w_next == ST_ACK) && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_wrack <= 1'b0;
            r_rdack <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wrack <= w_enter_ack &&  w_op_write;
            r_rdack <= w_enter_ack && !w_op_write;
            if (w_accept) begin
                r_cnt <= c_wait_load;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Request capture; later changes on the bus are ignored until IDLE.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_idx   <= Addr[DEPTH_LOG2-1:0];
            r_data  <= DI;
            r_be    <= w_be_in;
            r_write <= WE;
        end
    end

    vproc_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (Clk),
        .rst     (Reset),
        .i_we    (w_enter_ack &&  w_op_write),
        .i_re    (w_enter_ack && !w_op_write),
        .i_idx   (w_op_idx),
        .i_wdata (w_op_data),
        .i_be    (w_op_be),
        .o_rdata (DO)
    );

    assign WRAck = r_wrack;
    assign RDAck = r_rdack;

endmodule : vproc_mem
`default_nettype wire

// File: tb/tb_vproc_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_vproc_mem
// Description : Self-checking bench for vproc_mem. Three instances share the
//               clock and reset: WAIT_STATES 0, 3 and 1. A per-instance
//               reference memory supplies expected read data, which is
//               queued when a read is issued and popped at RDAck.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vproc_mem;

    logic        clk;
    logic        rst;
    logic [31:0] addr  [3];
    logic [31:0] di    [3];
    logic [31:0] dout  [3];
    logic [3:0]  be    [3];
    logic        we    [3];
    logic        rd    [3];
    logic        wrack [3];
    logic        rdack [3];

    logic [31:0] model [3][1024];
    logic [31:0] exp_q [$];

    int total  = 0;
    int passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vproc_mem #(.WAIT_STATES(0)) u_ws0 (
        .Clk(clk), .Reset(rst), .Addr(addr[0]), .WE(we[0]), .RD(rd[0]), .DI(di[0]),
`ifdef VPROC_MEM_BYTE_EN
        .BE(be[0]),
`endif
        .DO(dout[0]), .WRAck(wrack[0]), .RDAck(rdack[0])
    );

    vproc_mem #(.WAIT_STATES(3)) u_ws3 (
        .Clk(clk), .Reset(rst), .Addr(addr[1]), .WE(we[1]), .RD(rd[1]), .DI(di[1]),
`ifdef VPROC_MEM_BYTE_EN
        .BE(be[1]),
`endif
        .DO(dout[1]), .WRAck(wrack[1]), .RDAck(rdack[1])
    );

    vproc_mem #(.WAIT_STATES(1)) u_ws1 (
        .Clk(clk), .Reset(rst), .Addr(addr[2]), .WE(we[2]), .RD(rd[2]), .DI(di[2]),
`ifdef VPROC_MEM_BYTE_EN
        .BE(be[2]),
`endif
        .DO(dout[2]), .WRAck(wrack[2]), .RDAck(rdack[2])
    );

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] b);
        logic [9:0] idx;
        idx = a[9:0];
        for (int l = 0; l < 4; l++) begin
            if (b[l]) model[k][idx][l*8 +: 8] = d[l*8 +: 8];
        end
    endtask

    // One request from an IDLE start. mut_a (if nonzero) replaces Addr one
    // cycle after acceptance to prove the request was captured.
    task automatic op(input int k, input bit wr, input bit both, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic [31:0] mut_a,
                      input string tag);
        int lat;
        bit got;
        logic [31:0] expd;
        @(negedge clk);
        addr[k] = a; di[k] = d; be[k] = b;
        we[k] = wr; rd[k] = !wr || both;
        if (wr) model_write(k, a, d, b);
        else    exp_q.push_back(model[k][a[9:0]]);
        lat = 0; got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1 && mut_a != 32'h0) addr[k] = mut_a;
            if (wrack[k] || rdack[k]) got = 1'b1;
        end
        chk({tag, " ack"}, {31'b0, got}, 32'd1);
        if (got) begin
            chk({tag, " latency"}, lat, ws_of(k) + 1);
            chk({tag, " kind"}, {30'b0, wrack[k], rdack[k]}, wr ? 32'd2 : 32'd1);
            if (!wr) begin
                expd = exp_q.pop_front();
                chk({tag, " data"}, dout[k], expd);
            end
        end
        we[k] = 1'b0; rd[k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int gap;
        bit got;
        logic [31:0] v;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr[k] = 32'h0; di[k] = 32'h0; be[k] = 4'hF; we[k] = 1'b0; rd[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset DO", dout[k], 32'h0);
            chk("reset acks", {30'b0, wrack[k], rdack[k]}, 32'h0);
        end
        rst = 1'b0;

        // Zero wait states: basic write/read, DO hold across a write.
        op(0, 1, 0, 32'hA000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, "ws0 wr");
        op(0, 0, 0, 32'hA000_0010, 32'h0, 4'hF, 32'h0, "ws0 rd");
        op(0, 1, 0, 32'hA000_0010, 32'h0BAD_F00D, 4'hF, 32'h0, "ws0 wr2");
        chk("DO held over write", dout[0], 32'hDEAD_BEEF);
        op(0, 0, 0, 32'hA000_0010, 32'h0, 4'hF, 32'h0, "ws0 rd2");

        // Out-of-segment write held for 10 cycles.
        @(negedge clk);
        addr[0] = 32'hB000_0000; di[0] = 32'h1; we[0] = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (wrack[0] || rdack[0]) n++;
        end
        we[0] = 1'b0;
        chk("no-cs acks", n, 0);
        op(0, 0, 0, 32'hA000_0010, 32'h0, 4'hF, 32'h0, "after no-cs rd");

        // WE and RD together: write wins.
        op(0, 1, 1, 32'hA000_0000, 32'h5A5A_1234, 4'hF, 32'h0, "we+rd");
        op(0, 0, 0, 32'hA000_0000, 32'h0, 4'hF, 32'h0, "we+rd readback");

        // Three wait states: address change during WAIT is ignored.
        op(1, 1, 0, 32'hA000_0004, 32'h4444_4444, 4'hF, 32'h0, "ws3 wr4");
        op(1, 1, 0, 32'hA000_0008, 32'h8888_8888, 4'hF, 32'h0, "ws3 wr8");
        op(1, 0, 0, 32'hA000_0004, 32'h0, 4'hF, 32'hA000_0008, "ws3 rd mut");

        // Reset in WAIT aborts a write.
        op(1, 1, 0, 32'hA000_0020, 32'hCAFE_F00D, 4'hF, 32'h0, "ws3 wr20");
        op(1, 0, 0, 32'hA000_0020, 32'h0, 4'hF, 32'h0, "ws3 rd20");
        addr[1] = 32'hA000_0020; di[1] = 32'h1234_5678; we[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; we[1] = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (wrack[1] || rdack[1]) n++;
        end
        rst = 1'b0;
        chk("abort DO", dout[1], 32'h0);
        repeat (6) begin
            @(negedge clk);
            if (wrack[1] || rdack[1]) n++;
        end
        chk("abort acks", n, 0);
        op(1, 0, 0, 32'hA000_0020, 32'h0, 4'hF, 32'h0, "abort readback");

        // One wait state, back-to-back writes with WE held throughout.
        @(negedge clk);
        we[2] = 1'b1; rd[2] = 1'b0; be[2] = 4'hF;
        for (int i = 0; i < 16; i++) begin
            v = 32'h1000_0000 + 32'h0101_0101 * i;
            addr[2] = 32'hA000_0000 + i; di[2] = v;
            model_write(2, addr[2], v, 4'hF);
            gap = 0; got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(posedge clk);
                gap++;
                @(negedge clk);
                if (wrack[2]) got = 1'b1;
            end
            chk("b2b ack", {31'b0, got}, 32'd1);
            chk("b2b spacing", gap, (i == 0) ? 2 : 3);
        end
        we[2] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            op(2, 0, 0, 32'hA000_0000 + i, 32'h0, 4'hF, 32'h0, "b2b readback");
        end

        // Index wraps: bits above DEPTH_LOG2 are ignored.
        op(2, 1, 0, 32'hA000_0400, 32'h7777_7777, 4'hF, 32'h0, "wrap wr");
        op(2, 0, 0, 32'hA000_0000, 32'h0, 4'hF, 32'h0, "wrap rd");
        chk("wrap word0", dout[2], 32'h7777_7777);

`ifdef VPROC_MEM_BYTE_EN
        op(0, 1, 0, 32'hA000_0030, 32'h1122_3344, 4'hF, 32'h0, "be full");
        op(0, 1, 0, 32'hA000_0030, 32'hAABB_CCDD, 4'b0101, 32'h0, "be 0101");
        op(0, 0, 0, 32'hA000_0030, 32'h0, 4'hF, 32'h0, "be rd");
        chk("be merged", dout[0], 32'h11BB_33DD);
        op(0, 1, 0, 32'hA000_0030, 32'hFFFF_FFFF, 4'b0000, 32'h0, "be none");
        op(0, 0, 0, 32'hA000_0030, 32'h0, 4'hF, 32'h0, "be none rd");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_vproc_mem
`default_nettype wire

// File: doc/vproc_mem.md
# vproc_mem

Parametrised single-port memory model for VProc bus testbenches, replacing the fixed 1K-word, zero-wait, combinational-read memory. Decodes a configurable address segment and generates its own write/read acknowledges after a programmable number of wait states. Registers read data and captures request fields at acceptance. Sits directly on a VProc node's Addr/WE/RD/DataOut/DataIn/WRAck/RDAck signals.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8, 8..128
- DEPTH_LOG2, 10, log2 of word count; 1..28
- BASE_SEG, 4'hA, value of Addr[31:28] that selects this memory
- WAIT_STATES, 0, cycles inserted between acceptance and acknowledge; 0..15

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Addr  in  32  word address from VProc
- WE  in  1  write request, held by VProc until WRAck
- RD  in  1  read request, held by VProc until RDAck
- DI  in  DATA_WIDTH  write data (VProc DataOut)
- BE  in  DATA_WIDTH/8  byte lane enables; present only with VPROC_MEM_BYTE_EN
- DO  out  DATA_WIDTH  registered read data (VProc DataIn)
- WRAck  out  1  one-cycle write acknowledge
- RDAck  out  1  one-cycle read acknowledge

## Operation
- CS = (Addr[31:28] == BASE_SEG); word index = Addr[DEPTH_LOG2-1:0]; bits above the index are ignored.
- FSM states IDLE, WAIT, ACK.
- IDLE: if CS && (WE || RD), accept: capture index, DI, BE, op (write if WE, else read). Go to WAIT if WAIT_STATES > 0 (load counter WAIT_STATES-1), else ACK. Request without CS: ignored, stays IDLE, no ack.
- WE and RD together: write wins; RD not acknowledged this transaction.
- WAIT: decrement counter; at 0 go to ACK. Changes on Addr/DI/WE/RD during WAIT are ignored.
- ACK: exactly one of WRAck/RDAck high for this cycle only; go to IDLE.
- Write: array updated at the edge entering ACK using captured index/data.
- Read: DO loaded at the edge entering ACK; holds until the next read completes. Writes never change DO, including write to the index last read.
- Next request may be accepted in the IDLE cycle immediately after ACK (back-to-back throughput = WAIT_STATES + 2 cycles).
- Reset: state IDLE, counter 0, WRAck=0, RDAck=0, DO=0. Array contents not cleared. Reset during WAIT/ACK aborts the transaction: no ack issued, pending write not performed.

## Timing
- Request sampled at edge N in IDLE -> ack high in cycle after edge N+1+WAIT_STATES; DO valid in that same cycle.
- WAIT_STATES=0: ack one cycle after request seen.
- Ack is registered; no combinational path from any input to any output.

## Configuration
- VPROC_MEM_BYTE_EN defined: BE port exists; write updates only lanes with BE[i]=1; BE all-zero write still acknowledged, array unchanged.
- Undefined: no BE port; every write updates the full word.

## Structure
- Package vproc_mem_pkg: state enum (IDLE, WAIT, ACK), SEG_MSB/SEG_LSB constants (31/28), max WAIT_STATES constant.
- Sub-module vproc_mem_array: DEPTH × DATA_WIDTH storage, synchronous write with optional lane mask, synchronous registered read; top holds FSM, decode, capture and ack logic.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0xA0000010, then read 0xA0000010 -> WRAck one cycle after WE, RDAck one cycle after RD, DO=0xDEADBEEF.
- WAIT_STATES=3: read 0xA0000004 -> RDAck exactly 4 cycles after acceptance; changing Addr to 0xA0000008 during WAIT has no effect on returned data.
- Addr 0xB0000000 with WE held 10 cycles -> no WRAck, FSM stays IDLE; WE+RD together at 0xA0000000 -> only WRAck, data written.
- Reset asserted in WAIT of a write of 0x12345678 to 0xA0000020 -> no ack, DO=0; subsequent read of that index returns prior contents.
- VPROC_MEM_BYTE_EN: word 0x11223344, write 0xAABBCCDD with BE=4'b0101 -> read returns 0x11BB33DD.
- Back-to-back writes to 0xA0000000..0xA000000F with WAIT_STATES=1 -> one ack every 3 cycles, all 16 words read back correctly; index wraps for Addr 0xA0000400 (DEPTH_LOG2=10) onto word 0.
